// File: rtl/instr_loader.sv
// Streams 9-bit machine-code words into instruction memory through a registered write port.
// Tracks the program length and a running checksum, and holds the core stalled until a load completes.
module instr_loader #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [8:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [8:0]   wr_data,
    output logic [D:0]   prog_len,
    output logic [8:0]   checksum,
    output logic         core_hold,
    output logic         load_done,
    output logic         overflow_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    localparam logic [D:0] TOP_ADDR = {1'b0, {D{1'b1}}};

    state_t state, state_nxt;
    logic   accept;
    logic   at_top;

    assign in_ready     = (state == LOAD);
    assign core_hold    = (state != DONE);
    assign load_done    = (state == DONE);
    assign overflow_err = (state == ERROR);

    // start discards any word offered in the same cycle.
    assign accept = in_valid && in_ready && !start;
    assign at_top = (prog_len == TOP_ADDR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = LOAD;
        else if (accept) begin
            if (in_last)     state_nxt = DONE;
            else if (at_top) state_nxt = ERROR;
        end
    end

    // prog_len doubles as the write address counter; it only advances while in LOAD,
    // and LOAD is left at the top address, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            prog_len <= '0;
            checksum <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                prog_len <= '0;
                checksum <= '0;
            end else if (accept) begin
                wr_en    <= 1'b1;
                wr_addr  <= prog_len[D-1:0];
                wr_data  <= in_data;
                prog_len <= prog_len + 1'b1;
                checksum <= checksum ^ in_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (D=4) against a transaction-level model of the load protocol.
module tb_instr_loader;

    localparam int D     = 4;
    localparam int DEPTH = 1 << D;

    logic         clk = 1'b0;
    logic         reset, start, in_valid, in_last;
    logic [8:0]   in_data;
    logic         in_ready, wr_en, core_hold, load_done, overflow_err;
    logic [D-1:0] wr_addr;
    logic [8:0]   wr_data, checksum;
    logic [D:0]   prog_len;

    int errors = 0;
    int checks = 0;

    // model: mode 0=idle 1=loading 2=done 3=error
    int       m_mode;
    int       m_len;
    logic [8:0] m_sum;
    logic     m_we;
    int       m_addr;
    logic [8:0] m_data;

    instr_loader #(.D(D)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .checksum(checksum), .core_hold(core_hold),
        .load_done(load_done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] dut_vec();
        return {in_ready, wr_en, prog_len, checksum, core_hold, load_done, overflow_err};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {m_mode == 1, m_we, 5'(m_len), m_sum, m_mode != 2, m_mode == 2, m_mode == 3};
    endfunction

    // Drive one cycle, advance the model by the protocol rules, then sample after the edge.
    task automatic cyc(input logic r, input logic s, input logic v, input logic [8:0] d, input logic l);
        reset = r; start = s; in_valid = v; in_data = d; in_last = l;
        if (r) begin
            m_mode = 0; m_len = 0; m_sum = 0; m_we = 0;
        end else if (s) begin
            m_mode = 1; m_len = 0; m_sum = 0; m_we = 0;
        end else if (v && m_mode == 1) begin
            m_we = 1; m_addr = m_len; m_data = d;
            m_len = m_len + 1; m_sum = m_sum ^ d;
            if (l) m_mode = 2;
            else if (m_len == DEPTH) m_mode = 3;
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 1, 9'h1AA, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, prog_len, checksum, core_hold, load_done, overflow_err}
            !== {1'b0, 1'b0, 4'd0, 9'd0, 5'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got rdy=%b we=%b a=%0d d=%h len=%0d sum=%h hold=%b done=%b err=%b",
                     in_ready, wr_en, wr_addr, wr_data, prog_len, checksum, core_hold, load_done, overflow_err);
        end
    endtask

    task automatic test_back_to_back(input int gap);
        logic [8:0] w [3] = '{9'h03E, 9'h0CC, 9'h1F5};
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, w[i], i == 2);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'(i) || wr_data !== w[i]) begin
                errors++;
                $display("FAIL write gap%0d w%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                         gap, i, wr_en, wr_addr, wr_data, i, w[i]);
            end
            for (int g = 0; g < gap; g++) begin
                cyc(0, 0, 0, 9'h155, 0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL gap%0d idle got=%h exp=%h", gap, dut_vec(), exp_vec());
                end
            end
        end
        cyc(0, 0, 1, 9'h0FF, 0);
        checks++;
        if (load_done !== 1'b1 || core_hold !== 1'b0 || prog_len !== 5'd3 ||
            checksum !== 9'h107 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done gap%0d got done=%b hold=%b len=%0d sum=%h we=%b rdy=%b exp 1 0 3 107 0 0",
                     gap, load_done, core_hold, prog_len, checksum, wr_en, in_ready);
        end
    endtask

    task automatic test_fill(input logic last_at_end);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 9'($urandom), last_at_end && i == DEPTH - 1);
            checks++;
            if (dut_vec() !== exp_vec() || wr_addr !== 4'(m_addr) || wr_data !== m_data) begin
                errors++;
                $display("FAIL fill%0b w%0d got=%h a=%0d d=%h exp=%h a=%0d d=%h", last_at_end, i,
                         dut_vec(), wr_addr, wr_data, exp_vec(), m_addr, m_data);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 9'h1C3, 0);
            checks++;
            if (wr_en !== 1'b0 || prog_len !== 5'd16 || overflow_err !== !last_at_end ||
                load_done !== last_at_end || core_hold !== !last_at_end || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill%0b end got we=%b len=%0d err=%b done=%b hold=%b rdy=%b",
                         last_at_end, wr_en, prog_len, overflow_err, load_done, core_hold, in_ready);
            end
        end
    endtask

    task automatic test_abort();
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 9'($urandom), 0);
        cyc(0, 1, 1, 9'h0AB, 0);
        checks++;
        if (wr_en !== 1'b0 || prog_len !== 5'd0 || checksum !== 9'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort got we=%b len=%0d sum=%h rdy=%b exp 0 0 000 1", wr_en, prog_len, checksum, in_ready);
        end
        cyc(0, 0, 1, 9'h123, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 9'h123 || prog_len !== 5'd1) begin
            errors++;
            $display("FAIL abort_next got we=%b a=%0d d=%h len=%0d exp 1 0 123 1", wr_en, wr_addr, wr_data, prog_len);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 9'h011, 0);
        cyc(1, 0, 1, 9'h022, 0);
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, prog_len, checksum, core_hold, load_done, overflow_err}
            !== {1'b0, 1'b0, 4'd0, 9'd0, 5'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b we=%b a=%0d d=%h len=%0d sum=%h hold=%b",
                     in_ready, wr_en, wr_addr, wr_data, prog_len, checksum, core_hold);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 9'h033, 1);
            checks++;
            if (wr_en !== 1'b0 || prog_len !== 5'd0 || in_ready !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore got we=%b len=%0d rdy=%b done=%b", wr_en, prog_len, in_ready, load_done);
            end
        end
    endtask

    task automatic test_random();
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                9'($urandom), $urandom_range(0, 24) == 0);
            checks++;
            if (dut_vec() !== exp_vec() || (m_we && (wr_addr !== 4'(m_addr) || wr_data !== m_data))) begin
                errors++;
                $display("FAIL random c%0d got=%h a=%0d d=%h exp=%h a=%0d d=%h",
                         i, dut_vec(), wr_addr, wr_data, exp_vec(), m_addr, m_data);
            end
        end
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_data = 0; in_last = 0;
        test_reset();
        test_back_to_back(0);
        test_back_to_back(2);
        test_fill(1'b0);
        test_fill(1'b1);
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side counterpart of the instruction ROM: accepts 9-bit machine-code words over a valid/ready stream and writes them sequentially into instruction memory through a registered write port.
- Records the program length so fetch logic can stop at the real end instead of detecting unwritten (x) locations.
- Holds the core in a stall while the program is being loaded.

Parameters:
- D, 12, address width; instruction memory depth is 2**D words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a load at address 0.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_data  input  9  machine-code word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  loader can accept a word this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  D  write address.
- wr_data  output  9  write data.
- prog_len  output  D+1  number of words written in the current or last load.
- checksum  output  9  running XOR of all accepted words.
- core_hold  output  1  stalls the core (program counter frozen).
- load_done  output  1  load completed successfully.
- overflow_err  output  1  memory filled without in_last.

Behaviour:
- States: IDLE, LOAD, DONE, ERROR. Reset enters IDLE.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, prog_len=0, checksum=0, core_hold=1, load_done=0, overflow_err=0. The internal address counter resets to 0.
- A word is accepted only in a cycle with in_valid && in_ready. in_ready=1 only in LOAD. in_ready is combinational from state and is never dependent on in_valid.
- start, from any state: on the next edge go to LOAD, with address counter=0, prog_len=0, checksum=0, wr_en=0.
  - start aborts a load in progress. Any word presented in the same cycle as start is discarded.
  - start takes priority over acceptance.
- Accept at counter value A:
  - Next cycle: wr_en=1, wr_addr=A, wr_data=word. Write latency is 1 cycle.
  - Then counter=A+1, prog_len=A+1, checksum^=word.
  - wr_en=0 in every cycle that does not follow an accept.
- Back-to-back accepts give one write per cycle with consecutive addresses.
- Accept with in_last=1: next state DONE.
  - DONE outputs: load_done=1, core_hold=0, in_ready=0.
  - The final write occurs in the first DONE cycle.
- Accept at A=2**D-1 with in_last=0: that word is written.
  - Next state ERROR: overflow_err=1, core_hold=1, in_ready=0, prog_len=2**D.
- Accept at A=2**D-1 with in_last=1: normal DONE with prog_len=2**D. No error.
- The counter never wraps. After 2**D accepts, no further write occurs until start.
- core_hold=1 in IDLE, LOAD and ERROR; core_hold=0 only in DONE.
- In IDLE, DONE and ERROR, in_valid is ignored and prog_len/checksum hold their values.
- Reset mid-load: the next cycle is IDLE with all reset values. A pending write is not issued.

Test Plan:
- D=4, reset then start, then 3 back-to-back words 9'h03E, 9'h0CC, 9'h1F5 (last on the third) -> wr_en for 3 consecutive cycles, addresses 0,1,2, data matching. Then load_done=1, core_hold=0, prog_len=3, checksum=9'h107.
- Same 3 words with in_valid gaps of 2 idle cycles between words -> writes occur only 1 cycle after each accept, wr_en=0 in the gaps, same final prog_len=3 and checksum.
- D=4, 16 words with no in_last -> 16 writes to addresses 0..15, then overflow_err=1, in_ready=0, core_hold=1, prog_len=16. A further in_valid produces no write.
- D=4, 16 words with in_last on the 16th -> load_done=1, overflow_err=0, prog_len=16.
- Load 5 words, then pulse start together with in_valid on word 6 -> word 6 is not written. Next accepted word writes to address 0. prog_len=0 and checksum=0 in the cycle after start.
- Assert reset during LOAD right after an accept -> no wr_en the next cycle, all outputs at reset values, state IDLE. in_valid stays ignored until start.
